// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential word reads from variable-latency memory into a
// DEPTH-entry {pc, instr} FIFO presented to decode, flushed on branch/jump redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [31:0]     drop_addr_reg, drop_addr_next;
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            push, pop, space_now, space_after;
  logic [CW-1:0]   occ_after;
  logic [31:0]     redirect_aligned;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign out_valid = (count_reg != '0) && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign count     = count_reg;

  // An issue from IDLE may be acked in the same cycle, so the issue test only needs
  // room after this edge's pop; the stay-in-WAIT test also accounts for the push.
  assign space_now   = (count_reg != CW'(DEPTH)) || pop;
  assign occ_after   = count_reg + CW'(push) - CW'(pop);
  assign space_after = occ_after < CW'(DEPTH);

  assign mem_req  = rst && ((state_reg != S_IDLE) || (!redirect && space_now));
  assign mem_addr = (state_reg == S_DROP) ? drop_addr_reg : fetch_pc_reg;
  assign push     = mem_req && mem_ack && (state_reg != S_DROP) && !redirect;

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    drop_addr_next = drop_addr_reg;
    case (state_reg)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end else if (space_now) begin
          if (mem_ack) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
            state_next    = space_after ? S_WAIT : S_IDLE;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
          if (mem_ack) begin
            state_next = S_IDLE;
          end else begin
            // Request cannot be retracted: keep presenting the old address until acked.
            state_next     = S_DROP;
            drop_addr_next = fetch_pc_reg;
          end
        end else if (mem_ack) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          state_next    = space_after ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect) fetch_pc_next = redirect_aligned;
        if (mem_ack)  state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      fetch_pc_reg  <= RESET_PC;
      drop_addr_reg <= RESET_PC;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      drop_addr_reg <= drop_addr_next;
      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        rd_ptr_reg <= rd_ptr_reg + PW'(pop);
        wr_ptr_reg <= wr_ptr_reg + PW'(push);
        count_reg  <= occ_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= mem_rdata;
    end
  end
endmodule
